// File: rtl/alu_pkg.sv
// Shared opcode constants, result-entry payload and capture-state type for the ALU result buffer.
package alu_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [OP_W-1:0] OP_ADD = 5'd6;
  localparam logic [OP_W-1:0] OP_SUB = 5'd7;

  // One buffered add/sub result with its precomputed flags.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              overflow;
    logic              zero;
    logic              negative;
  } result_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } cap_state_e;

  // True for the opcodes that produce an add/sub result worth buffering.
  function automatic logic is_addsub(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO: storage, wrapping pointers and occupancy count.
// Flag storage is only built when FLAGS_EN is set; otherwise head flags read as 0.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter bit          FLAGS_EN = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  result_t                  wdata_i,
  output result_t                  rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic              ovf_q  [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_en_c;
  logic              pop_en_c;
  logic              head_zero_c;
  logic              head_neg_c;

  assign full_o    = (count_q == CW'(DEPTH));
  assign pop_en_c  = pop_i && (count_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_en_c = push_i && (!full_o || pop_en_c);

  // Pointer and count next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_en_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_en_c) - CW'(pop_en_c);
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data and overflow storage, cleared on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        ovf_q[i]  <= 1'b0;
      end
    end else if (push_en_c) begin
      data_q[wr_ptr_q] <= wdata_i.data;
      ovf_q[wr_ptr_q]  <= wdata_i.overflow;
    end
  end

  if (FLAGS_EN) begin : g_flags
    logic zero_q [DEPTH];
    logic neg_q  [DEPTH];

    // Flag storage alongside each entry, cleared on reset.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          zero_q[i] <= 1'b0;
          neg_q[i]  <= 1'b0;
        end
      end else if (push_en_c) begin
        zero_q[wr_ptr_q] <= wdata_i.zero;
        neg_q[wr_ptr_q]  <= wdata_i.negative;
      end
    end

    assign head_zero_c = zero_q[rd_ptr_q];
    assign head_neg_c  = neg_q[rd_ptr_q];
  end else begin : g_no_flags
    logic unused_flags;
    assign unused_flags = ^{wdata_i.zero, wdata_i.negative};
    assign head_zero_c  = 1'b0;
    assign head_neg_c   = 1'b0;
  end

  assign rdata_o = '{data:     data_q[rd_ptr_q],
                     overflow: ovf_q[rd_ptr_q],
                     zero:     head_zero_c,
                     negative: head_neg_c};
  assign count_o = count_q;

endmodule

// File: rtl/alu_result_buffer.sv
// ALU result buffer: captures add/sub results one cycle after dat_ready and queues them for writeback.
// Optional macro ALU_RESULT_FLAGS_EN enables stored zero/negative flags; when undefined they read 0.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              soc_clk,
  input  logic              reset,
  input  logic              dat_ready,
  input  logic [OP_W-1:0]   Instruction_to_ALU,
  input  logic [DATA_W-1:0] AddSub_out,
  input  logic              AddSub_overflow,
  input  logic              wb_ready,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_overflow,
  output logic              wb_zero,
  output logic              wb_negative,
  output logic              busy,
  output logic              drop_err
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CW + 1;

`ifdef ALU_RESULT_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  cap_state_e        state_q, state_d;
  logic              drop_err_q, drop_err_d;
  logic              push_c;
  logic              pop_c;
  logic              full_c;
  logic [CW-1:0]     count_c;
  logic [OCC_W-1:0]  occ_c;
  result_t           wdata_c;
  result_t           head_c;

  // Capture FSM next-state: any qualifying dat_ready leads to PEND for the following cycle.
  always_comb begin
    state_d = ST_IDLE;
    push_c  = 1'b0;
    if (state_q == ST_PEND) push_c = 1'b1;
    if (dat_ready && is_addsub(Instruction_to_ALU)) state_d = ST_PEND;
  end

  // Capture FSM state register.
  always_ff @(posedge soc_clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Flags are derived from the result while it is being pushed.
  always_comb begin
    wdata_c          = '0;
    wdata_c.data     = AddSub_out;
    wdata_c.overflow = AddSub_overflow;
`ifdef ALU_RESULT_FLAGS_EN
    wdata_c.zero     = (AddSub_out == '0);
    wdata_c.negative = AddSub_out[DATA_W-1];
`endif
  end

  assign pop_c = wb_valid && wb_ready;

  // Sticky drop indication: a push arrived with no room and no same-cycle pop.
  always_comb begin
    drop_err_d = drop_err_q;
    if (push_c && full_c && !pop_c) drop_err_d = 1'b1;
  end

  // Drop error register.
  always_ff @(posedge soc_clk) begin
    if (!reset) drop_err_q <= 1'b0;
    else        drop_err_q <= drop_err_d;
  end

  alu_result_fifo #(
    .DEPTH    (DEPTH),
    .FLAGS_EN (FLAGS_EN)
  ) u_fifo (
    .clk_i   (soc_clk),
    .rst_ni  (reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (wdata_c),
    .rdata_o (head_c),
    .count_o (count_c),
    .full_o  (full_c)
  );

  // A pending capture already claims a slot, so it counts toward busy.
  assign occ_c = {1'b0, count_c} + OCC_W'(state_q == ST_PEND);
  assign busy  = (occ_c >= OCC_W'(DEPTH));

  assign wb_valid    = (count_c != '0);
  assign wb_data     = head_c.data;
  assign wb_overflow = head_c.overflow;
  assign drop_err    = drop_err_q;

`ifdef ALU_RESULT_FLAGS_EN
  assign wb_zero     = head_c.zero;
  assign wb_negative = head_c.negative;
`else
  logic unused_head_flags;
  assign unused_head_flags = ^{head_c.zero, head_c.negative};
  assign wb_zero     = 1'b0;
  assign wb_negative = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: driver models accepted results, monitor checks the writeback head.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        soc_clk;
  logic        reset;
  logic        dat_ready;
  logic [4:0]  Instruction_to_ALU;
  logic [31:0] AddSub_out;
  logic        AddSub_overflow;
  logic        wb_ready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        wb_overflow;
  logic        wb_zero;
  logic        wb_negative;
  logic        busy;
  logic        drop_err;

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .soc_clk            (soc_clk),
    .reset              (reset),
    .dat_ready          (dat_ready),
    .Instruction_to_ALU (Instruction_to_ALU),
    .AddSub_out         (AddSub_out),
    .AddSub_overflow    (AddSub_overflow),
    .wb_ready           (wb_ready),
    .wb_valid           (wb_valid),
    .wb_data            (wb_data),
    .wb_overflow        (wb_overflow),
    .wb_zero            (wb_zero),
    .wb_negative        (wb_negative),
    .busy               (busy),
    .drop_err           (drop_err)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  // Reference state: expected entries in order, occupancy, sticky drop, result owed next cycle.
  result_t sb[$];
  int      m_cnt;
  bit      m_drop;
  bit      m_owed;
  bit      in_reset;
  bit      started;
  int      checks;
  int      errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference by one clock edge using the inputs held at that edge.
  task automatic model_step();
    result_t e;
    if (!reset) begin
      sb.delete();
      m_cnt    = 0;
      m_drop   = 1'b0;
      m_owed   = 1'b0;
      in_reset = 1'b1;
    end else begin
      in_reset = 1'b0;
      if (m_cnt != 0 && wb_ready) m_cnt--;
      if (m_owed) begin
        e.data     = AddSub_out;
        e.overflow = AddSub_overflow;
`ifdef ALU_RESULT_FLAGS_EN
        e.zero     = (AddSub_out == 32'd0);
        e.negative = AddSub_out[31];
`else
        e.zero     = 1'b0;
        e.negative = 1'b0;
`endif
        if (m_cnt < int'(DEPTH)) begin
          sb.push_back(e);
          m_cnt++;
        end else begin
          m_drop = 1'b1;
        end
      end
      m_owed = dat_ready && (Instruction_to_ALU == 5'd6 || Instruction_to_ALU == 5'd7);
    end
  endtask

  task automatic cycle(input logic rdy, input logic [4:0] op, input logic [31:0] dout,
                       input logic ovf, input logic wbr, input logic rst_n);
    dat_ready          = rdy;
    Instruction_to_ALU = op;
    AddSub_out         = dout;
    AddSub_overflow    = ovf;
    wb_ready           = wbr;
    reset              = rst_n;
    @(posedge soc_clk);
    model_step();
    started = 1'b1;
    #1;
  endtask

  // Monitor: compares DUT outputs against the reference mid-cycle, pops on handshake.
  always @(negedge soc_clk) begin
    if (started) begin
      if (in_reset) begin
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_flags", 32'({wb_overflow, wb_zero, wb_negative}), 32'd0);
      end else begin
        chk("valid", 32'(wb_valid), 32'(m_cnt != 0));
        chk("busy", 32'(busy), 32'((m_cnt + int'(m_owed)) >= int'(DEPTH)));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
        if (wb_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_entry", 32'(wb_valid), 32'd0);
          end else begin
            chk("data", wb_data, sb[0].data);
            chk("overflow", 32'(wb_overflow), 32'(sb[0].overflow));
            chk("zero", 32'(wb_zero), 32'(sb[0].zero));
            chk("negative", 32'(wb_negative), 32'(sb[0].negative));
            if (wb_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    started = 1'b0;
    checks  = 0;
    errors  = 0;
    m_cnt   = 0;
    m_drop  = 1'b0;
    m_owed  = 1'b0;
    in_reset = 1'b1;
    dat_ready = 1'b0; Instruction_to_ALU = 5'd0; AddSub_out = 32'd0;
    AddSub_overflow = 1'b0; wb_ready = 1'b0; reset = 1'b0;

    // Reset
    cycle(0, 5'd0, 32'd0, 0, 0, 0);
    cycle(0, 5'd0, 32'd0, 0, 1, 0);

    // ADD path: result arrives the cycle after dat_ready, held until wb_ready
    cycle(1, 5'd6, 32'hdead_beef, 0, 0, 1);
    cycle(0, 5'd0, 32'h0000_0005, 0, 0, 1);
    cycle(0, 5'd0, 32'h1111_1111, 1, 0, 1);
    cycle(0, 5'd0, 32'd0, 0, 1, 1);
    cycle(0, 5'd0, 32'd0, 0, 1, 1);

    // SUB flags: zero result, then negative with overflow
    cycle(1, 5'd7, 32'd1, 0, 0, 1);
    cycle(1, 5'd7, 32'h0000_0000, 0, 0, 1);
    cycle(0, 5'd0, 32'h8000_0000, 1, 1, 1);
    cycle(0, 5'd0, 32'd0, 0, 1, 1);
    cycle(0, 5'd0, 32'd0, 0, 1, 1);

    // Non-add opcode never pushes
    cycle(1, 5'd3, 32'h1234_5678, 1, 0, 1);
    cycle(1, 5'd3, 32'h1234_5678, 1, 0, 1);
    cycle(0, 5'd0, 32'd0, 0, 0, 1);

    // Backpressure: three back-to-back ops, third dropped, then drain
    cycle(1, 5'd6, 32'd0, 0, 0, 1);
    cycle(1, 5'd6, 32'hA0A0_0001, 0, 0, 1);
    cycle(1, 5'd7, 32'hA0A0_0002, 1, 0, 1);
    cycle(0, 5'd0, 32'hA0A0_0003, 0, 0, 1);
    cycle(0, 5'd0, 32'd0, 0, 0, 1);
    cycle(0, 5'd0, 32'd0, 0, 1, 1);
    cycle(0, 5'd0, 32'd0, 0, 1, 1);
    cycle(0, 5'd0, 32'd0, 0, 1, 1);

    // Full FIFO with continuous push and pop across pointer wrap
    cycle(1, 5'd6, 32'd0, 0, 0, 1);
    cycle(1, 5'd6, 32'hB000_0001, 0, 0, 1);
    cycle(1, 5'd6, 32'hB000_0002, 0, 0, 1);
    for (int i = 3; i < 9; i++) cycle(1, 5'd6, 32'hB000_0000 + 32'(i), 0, 1, 1);
    cycle(0, 5'd0, 32'hB000_0009, 0, 1, 1);
    cycle(0, 5'd0, 32'd0, 0, 1, 1);
    cycle(0, 5'd0, 32'd0, 0, 1, 1);

    // Reset while a capture is pending: nothing appears afterwards
    cycle(1, 5'd7, 32'd0, 0, 0, 1);
    cycle(0, 5'd0, 32'hC0FF_EE00, 1, 0, 0);
    cycle(0, 5'd0, 32'd0, 0, 0, 1);
    cycle(0, 5'd0, 32'd0, 0, 1, 1);

    // Randomized traffic, including busy violations and occasional resets
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  op_v;
      logic [31:0] d_v;
      case ($urandom_range(0, 3))
        0: op_v = 5'd6;
        1: op_v = 5'd7;
        2: op_v = 5'd3;
        default: op_v = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 5))
        0: d_v = 32'd0;
        1: d_v = 32'h8000_0000 | 32'($urandom);
        default: d_v = 32'($urandom);
      endcase
      cycle(1'($urandom_range(0, 1)), op_v, d_v, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) != 0));
    end

    // Drain
    for (int n = 0; n < 6; n++) cycle(0, 5'd0, 32'd0, 0, 1, 1);
    chk("final_empty", 32'(wb_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
